// File: rtl/idli_pkg.sv
// idli_pkg: shared types and constants for the idli SQI memory responder.
//   slice_t      one SIO nibble
//   sqi_state_t  responder FSM states
//   SQI_*        command codes, address length and nibble-counter width
package idli_pkg;

  typedef logic [3:0] slice_t;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    RD_DATA,
    WR_DATA,
    IGNORE
  } sqi_state_t;

  localparam logic [7:0] SQI_CMD_READ  = 8'h03;
  localparam logic [7:0] SQI_CMD_WRITE = 8'h02;
  localparam int         SQI_ADDR_NIBS = 6;

  // Wide enough for the address nibble count and any sensible dummy count.
  localparam int         SQI_NIB_CNT_W = 4;

endpackage

// File: rtl/idli_sqi_ram_m.sv
// idli_sqi_ram_m: 2^ADDR_W x 8 byte RAM backing the SQI responder.
//   clk_i                         clock
//   a_we_i/a_addr_i/a_wdata_i     port A (FSM): synchronous write
//   a_rdata_o                     port A asynchronous read
//   b_we_i/b_addr_i/b_wdata_i     port B (backdoor): synchronous write
//   b_rdata_o                     port B asynchronous read
// When both ports write the same address in one cycle, port B's data is kept.
module idli_sqi_ram_m #(
  parameter int ADDR_W = 16
) (
  input  logic              clk_i,
  input  logic              a_we_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [7:0]        a_wdata_i,
  output logic [7:0]        a_rdata_o,
  input  logic              b_we_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [7:0]        b_wdata_i,
  output logic [7:0]        b_rdata_o
);

  logic [7:0] mem_q [0:(2**ADDR_W)-1];

  logic a_blocked;
  assign a_blocked = b_we_i && (a_addr_i == b_addr_i);

  always_ff @(posedge clk_i) begin
    if (a_we_i && !a_blocked) begin
      mem_q[a_addr_i] <= a_wdata_i;
    end
    if (b_we_i) begin
      mem_q[b_addr_i] <= b_wdata_i;
    end
  end

  assign a_rdata_o = mem_q[a_addr_i];
  assign b_rdata_o = mem_q[b_addr_i];

endmodule

// File: rtl/idli_sqi_mem_m.sv
// idli_sqi_mem_m: SQI responder (SRAM model) for one idli memory port.
// Oversamples SCK/CS in the gck domain, runs sequential READ (0x03) and
// WRITE (0x02) against a byte RAM, and drives read nibbles on SIO.
//   i_mem_gck/i_mem_rst        clock, synchronous active-high reset
//   i_mem_sck/i_mem_cs         SQI clock, active-low chip select
//   i_mem_sio                  nibble from initiator
//   o_mem_sio/o_mem_sio_oe     registered nibble to initiator and its enable
//   i_mem_bd_*/o_mem_bd_rdata  backdoor byte access (bench preload / peek)
//
// state   | meaning
// IDLE    | waiting for CS low
// CMD     | shifting in 2 command nibbles
// ADDR    | shifting in 6 address nibbles, MSB first
// DUMMY   | DUMMY_NIBS turnaround rises before read data
// RD_DATA | driving read nibbles on SCK falls, auto-increment
// WR_DATA | collecting nibble pairs into RAM bytes, auto-increment
// IGNORE  | unknown command, silent until CS high
module idli_sqi_mem_m
  import idli_pkg::*;
#(
  parameter int MEM_ADDR_W = 16,
  parameter int DUMMY_NIBS = 2
) (
  input  logic                  i_mem_gck,
  input  logic                  i_mem_rst,
  input  logic                  i_mem_sck,
  input  logic                  i_mem_cs,
  input  slice_t                i_mem_sio,
  output slice_t                o_mem_sio,
  output logic                  o_mem_sio_oe,
  input  logic                  i_mem_bd_we,
  input  logic [MEM_ADDR_W-1:0] i_mem_bd_addr,
  input  logic [7:0]            i_mem_bd_wdata,
  output logic [7:0]            o_mem_bd_rdata
);

  localparam logic [SQI_NIB_CNT_W-1:0] NIB_ONE   = SQI_NIB_CNT_W'(1);
  localparam logic [SQI_NIB_CNT_W-1:0] ADDR_LAST = SQI_NIB_CNT_W'(SQI_ADDR_NIBS - 1);
  localparam logic [SQI_NIB_CNT_W-1:0] DUMY_LAST = SQI_NIB_CNT_W'(DUMMY_NIBS - 1);
  localparam logic [MEM_ADDR_W-1:0]    ADDR_ONE  = MEM_ADDR_W'(1);

  sqi_state_t                state_q;
  logic                      sck_q;
  logic                      cs_q;
  logic [SQI_NIB_CNT_W-1:0]  nib_cnt_q;
  slice_t                    cmd_hi_q;
  logic                      is_wr_q;
  logic [MEM_ADDR_W-1:0]     addr_q;
  logic [7:0]                rd_byte_q;
  slice_t                    wr_hi_q;
  logic                      half_q;
  slice_t                    sio_q;
  logic                      oe_q;

  logic                      sck_rise;
  logic                      sck_fall;
  logic                      ram_we;
  logic [MEM_ADDR_W-1:0]     ram_addr_d;
  logic [7:0]                ram_rdata;

  assign sck_rise = i_mem_sck & ~sck_q;
  assign sck_fall = ~i_mem_sck & sck_q;

  // In RD_DATA the RAM port looks one byte ahead so rd_byte can be reloaded
  // on the same fall that advances addr.
  assign ram_addr_d = (state_q == RD_DATA) ? (addr_q + ADDR_ONE) : addr_q;
  assign ram_we     = !i_mem_cs && (state_q == WR_DATA) && sck_rise && half_q;

  idli_sqi_ram_m #(
    .ADDR_W (MEM_ADDR_W)
  ) u_ram (
    .clk_i     (i_mem_gck),
    .a_we_i    (ram_we),
    .a_addr_i  (ram_addr_d),
    .a_wdata_i ({wr_hi_q, i_mem_sio}),
    .a_rdata_o (ram_rdata),
    .b_we_i    (i_mem_bd_we),
    .b_addr_i  (i_mem_bd_addr),
    .b_wdata_i (i_mem_bd_wdata),
    .b_rdata_o (o_mem_bd_rdata)
  );

  always_ff @(posedge i_mem_gck) begin
    if (i_mem_rst) begin
      state_q   <= IDLE;
      sck_q     <= 1'b0;
      cs_q      <= 1'b1;
      nib_cnt_q <= '0;
      cmd_hi_q  <= '0;
      is_wr_q   <= 1'b0;
      addr_q    <= '0;
      rd_byte_q <= '0;
      wr_hi_q   <= '0;
      half_q    <= 1'b0;
      sio_q     <= '0;
      oe_q      <= 1'b0;
    end else begin
      sck_q <= i_mem_sck;
      cs_q  <= i_mem_cs;
      if (i_mem_cs) begin
        // CS high aborts everything, including a half-collected write byte.
        state_q   <= IDLE;
        nib_cnt_q <= '0;
        half_q    <= 1'b0;
        sio_q     <= '0;
        oe_q      <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            // Require CS low on two samples so a fresh select is settled.
            if (!cs_q) begin
              state_q   <= CMD;
              nib_cnt_q <= '0;
            end
          end
          CMD: begin
            if (sck_rise) begin
              cmd_hi_q <= i_mem_sio;
              if (nib_cnt_q == NIB_ONE) begin
                nib_cnt_q <= '0;
                if ({cmd_hi_q, i_mem_sio} == SQI_CMD_READ) begin
                  is_wr_q <= 1'b0;
                  state_q <= ADDR;
                end else if ({cmd_hi_q, i_mem_sio} == SQI_CMD_WRITE) begin
                  is_wr_q <= 1'b1;
                  state_q <= ADDR;
                end else begin
                  state_q <= IGNORE;
                end
              end else begin
                nib_cnt_q <= nib_cnt_q + NIB_ONE;
              end
            end
          end
          ADDR: begin
            if (sck_rise) begin
              // Upper bus-address bits fall off the top of the shift.
              addr_q <= {addr_q[MEM_ADDR_W-5:0], i_mem_sio};
              if (nib_cnt_q == ADDR_LAST) begin
                nib_cnt_q <= '0;
                half_q    <= 1'b0;
                state_q   <= is_wr_q ? WR_DATA : DUMMY;
              end else begin
                nib_cnt_q <= nib_cnt_q + NIB_ONE;
              end
            end
          end
          DUMMY: begin
            if (sck_rise) begin
              if (nib_cnt_q == DUMY_LAST) begin
                nib_cnt_q <= '0;
                half_q    <= 1'b0;
                rd_byte_q <= ram_rdata;
                state_q   <= RD_DATA;
              end else begin
                nib_cnt_q <= nib_cnt_q + NIB_ONE;
              end
            end
          end
          RD_DATA: begin
            if (sck_fall) begin
              oe_q <= 1'b1;
              if (!half_q) begin
                sio_q  <= rd_byte_q[7:4];
                half_q <= 1'b1;
              end else begin
                sio_q     <= rd_byte_q[3:0];
                half_q    <= 1'b0;
                addr_q    <= addr_q + ADDR_ONE;
                rd_byte_q <= ram_rdata;
              end
            end
          end
          WR_DATA: begin
            if (sck_rise) begin
              if (!half_q) begin
                wr_hi_q <= i_mem_sio;
                half_q  <= 1'b1;
              end else begin
                half_q <= 1'b0;
                addr_q <= addr_q + ADDR_ONE;
              end
            end
          end
          IGNORE: begin
            state_q <= IGNORE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign o_mem_sio    = sio_q;
  assign o_mem_sio_oe = oe_q;

endmodule
